ccr_branch_ctrl: RTL and testbench

- Consumer side of the condition code register: reads the 4-bit CCR and resolves conditional and unconditional jumps.
- On a taken conditional jump, issues a clear-flag write back to the CCR through its flag_en/flag_mask port, with the flag data driven to 0 by the top level.
- Owns the CCR shadow copy for interrupt entry and return (save on interrupt, restore on RTI).
- Sits between decode/EX and the PC/CCR; drives PC load and the pipeline flush.

---
 rtl/ccr_pkg.sv | 25 ++
 rtl/ccr_branch_ctrl_cond.sv | 31 +++
 rtl/ccr_branch_ctrl.sv | 147 ++++++++++++++
 tb/tb_ccr_branch_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccr_pkg.sv
// ccr_pkg: shared flag indices, branch opcodes and FSM states for the CCR block family
package ccr_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef logic [2:0] br_op_t;

    localparam br_op_t BR_NONE = 3'd0;
    localparam br_op_t BR_JZ   = 3'd1;
    localparam br_op_t BR_JN   = 3'd2;
    localparam br_op_t BR_JC   = 3'd3;
    localparam br_op_t BR_JV   = 3'd4;
    localparam br_op_t BR_JMP  = 3'd5;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    function automatic logic [3:0] flag_onehot(input int idx);
        return 4'(1) << idx;
    endfunction

endpackage

// File: rtl/ccr_branch_ctrl_cond.sv
// ccr_branch_ctrl_cond: forwards in-flight ALU flags over the CCR and evaluates the branch condition
module ccr_branch_ctrl_cond
    import ccr_pkg::*;
(
    input  logic       [3:0] ccr_i,
    input  logic             flag_en_i,
    input  logic       [3:0] flag_mask_i,
    input  logic       [3:0] flags_i,
    input  br_op_t           op_i,
    output logic       [3:0] eff_o,
    output logic             take_o,
    output logic             cond_o,
    output logic       [3:0] mask_o
);

    logic [3:0] fwd;

    assign fwd   = {4{flag_en_i}} & flag_mask_i;
    assign eff_o = (flags_i & fwd) | (ccr_i & ~fwd);

    // One-hot of the tested flag; zero for JMP, NONE and undefined codes
    always_comb begin
        mask_o = (op_i == BR_JZ) ? flag_onehot(FLAG_Z) :
                 (op_i == BR_JN) ? flag_onehot(FLAG_N) :
                 (op_i == BR_JC) ? flag_onehot(FLAG_C) :
                 (op_i == BR_JV) ? flag_onehot(FLAG_V) : 4'b0000;
        cond_o = |mask_o;
        take_o = (op_i == BR_JMP) || |(mask_o & eff_o);
    end

endmodule

// File: rtl/ccr_branch_ctrl.sv
// ccr_branch_ctrl: resolves jumps against the CCR, clears tested flags, owns the interrupt CCR shadow
module ccr_branch_ctrl
    import ccr_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [3:0]        ccr_in_i,
    input  logic              alu_flag_en_i,
    input  logic [3:0]        alu_flag_mask_i,
    input  logic [3:0]        alu_flags_i,
    input  logic              br_valid_i,
    input  logic [2:0]        br_op_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              int_req_i,
    input  logic              rti_i,
    output logic              pc_load_o,
    output logic [ADDR_W-1:0] pc_target_o,
    output logic              flush_o,
    output logic              clr_en_o,
    output logic [3:0]        clr_mask_o,
    output logic              int_save_o,
    output logic              restore_en_o,
    output logic [3:0]        restore_val_o,
    output logic              busy_o
);

    localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [3:0]        shadow_q, shadow_d;
    logic              pc_load_q, pc_load_d;
    logic [ADDR_W-1:0] pc_target_q, pc_target_d;
    logic              flush_q, flush_d;
    logic              clr_en_q, clr_en_d;
    logic [3:0]        clr_mask_q, clr_mask_d;
    logic              int_save_q, int_save_d;
    logic              restore_en_q, restore_en_d;
    logic [3:0]        restore_val_q, restore_val_d;

    logic       take, cond;
    logic [3:0] eff, cmask;

    ccr_branch_ctrl_cond u_cond (
        .ccr_i       (ccr_in_i),
        .flag_en_i   (alu_flag_en_i),
        .flag_mask_i (alu_flag_mask_i),
        .flags_i     (alu_flags_i),
        .op_i        (br_op_i),
        .eff_o       (eff),
        .take_o      (take),
        .cond_o      (cond),
        .mask_o      (cmask)
    );

    // Next state: branch beats interrupt, restore beats interrupt, pending serviced in IDLE
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        shadow_d      = shadow_q;
        pc_load_d     = 1'b0;
        pc_target_d   = pc_target_q;
        flush_d       = flush_q;
        clr_en_d      = 1'b0;
        clr_mask_d    = 4'b0000;
        int_save_d    = 1'b0;
        restore_en_d  = rti_i;
        restore_val_d = rti_i ? shadow_q : restore_val_q;
        if (state_q == ST_IDLE) begin
            if (br_valid_i && take) begin
                pc_load_d   = 1'b1;
                pc_target_d = br_target_i;
                clr_en_d    = cond;
                clr_mask_d  = cmask;
                flush_d     = 1'b1;
                state_d     = ST_FLUSH;
                cnt_d       = CNT_INIT;
                pend_d      = pend_q | int_req_i;
            end else if ((int_req_i || pend_q) && !rti_i) begin
                shadow_d    = eff;
                int_save_d  = 1'b1;
                pend_d      = 1'b0;
                flush_d     = 1'b1;
                state_d     = ST_FLUSH;
                cnt_d       = CNT_INIT;
            end else begin
                pend_d      = pend_q | int_req_i;
            end
        end else begin
            pend_d = pend_q | int_req_i;
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
                flush_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            shadow_q      <= 4'b0000;
            pc_load_q     <= 1'b0;
            pc_target_q   <= '0;
            flush_q       <= 1'b0;
            clr_en_q      <= 1'b0;
            clr_mask_q    <= 4'b0000;
            int_save_q    <= 1'b0;
            restore_en_q  <= 1'b0;
            restore_val_q <= 4'b0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            shadow_q      <= shadow_d;
            pc_load_q     <= pc_load_d;
            pc_target_q   <= pc_target_d;
            flush_q       <= flush_d;
            clr_en_q      <= clr_en_d;
            clr_mask_q    <= clr_mask_d;
            int_save_q    <= int_save_d;
            restore_en_q  <= restore_en_d;
            restore_val_q <= restore_val_d;
        end
    end

    assign pc_load_o     = pc_load_q;
    assign pc_target_o   = pc_target_q;
    assign flush_o       = flush_q;
    assign clr_en_o      = clr_en_q;
    assign clr_mask_o    = clr_mask_q;
    assign int_save_o    = int_save_q;
    assign restore_en_o  = restore_en_q;
    assign restore_val_o = restore_val_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ccr_branch_ctrl.sv
// tb_ccr_branch_ctrl: table vectors, corner sequences and random stimulus against a cycle model
module tb_ccr_branch_ctrl;
    import ccr_pkg::*;

    localparam int AW = 8;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    ccr_in = '0;
    logic          alu_flag_en = 1'b0;
    logic [3:0]    alu_flag_mask = '0;
    logic [3:0]    alu_flags = '0;
    logic          br_valid = 1'b0;
    logic [2:0]    br_op = '0;
    logic [AW-1:0] br_target = '0;
    logic          int_req = 1'b0;
    logic          rti = 1'b0;
    logic          pc_load, flush, clr_en, int_save, restore_en, busy;
    logic [AW-1:0] pc_target;
    logic [3:0]    clr_mask, restore_val;

    ccr_branch_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ccr_in_i        (ccr_in),
        .alu_flag_en_i   (alu_flag_en),
        .alu_flag_mask_i (alu_flag_mask),
        .alu_flags_i     (alu_flags),
        .br_valid_i      (br_valid),
        .br_op_i         (br_op),
        .br_target_i     (br_target),
        .int_req_i       (int_req),
        .rti_i           (rti),
        .pc_load_o       (pc_load),
        .pc_target_o     (pc_target),
        .flush_o         (flush),
        .clr_en_o        (clr_en),
        .clr_mask_o      (clr_mask),
        .int_save_o      (int_save),
        .restore_en_o    (restore_en),
        .restore_val_o   (restore_val),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: remaining busy cycles, pending bit, shadow and expected outputs
    int            m_left;
    bit            m_pend;
    logic [3:0]    m_shadow;
    logic          m_load, m_clr, m_save, m_ren;
    logic [AW-1:0] m_tgt;
    logic [3:0]    m_cmask, m_rval;

    typedef struct {
        logic [3:0] ccr;
        logic       fen;
        logic [3:0] fmask;
        logic [3:0] flags;
        logic [2:0] op;
        logic [7:0] tgt;
        logic       load;
        logic       clr;
        logic [3:0] cmask;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_pend = 0; m_shadow = '0;
        m_load = 0; m_clr = 0; m_save = 0; m_ren = 0;
        m_tgt = '0; m_cmask = '0; m_rval = '0;
    endtask

    task automatic model_step();
        logic [3:0] eff;
        bit taken;
        int op;
        for (int i = 0; i < 4; i++)
            eff[i] = (alu_flag_en && alu_flag_mask[i]) ? alu_flags[i] : ccr_in[i];
        op = int'(br_op);
        taken = (op == 5) || ((op >= 1 && op <= 4) ? eff[op-1] : 1'b0);
        m_load = 0; m_clr = 0; m_cmask = '0; m_save = 0;
        m_ren = rti;
        if (rti) m_rval = m_shadow;
        if (m_left == 0) begin
            if (br_valid && taken) begin
                m_load = 1;
                m_tgt  = br_target;
                m_left = FC;
                m_pend = m_pend | int_req;
                if (op != 5) begin
                    m_clr   = 1;
                    m_cmask = 4'(1 << (op - 1));
                end
            end else if ((int_req || m_pend) && !rti) begin
                m_shadow = eff;
                m_save   = 1;
                m_pend   = 0;
                m_left   = FC;
            end else if (int_req) begin
                m_pend = 1;
            end
        end else begin
            m_pend = m_pend | int_req;
            m_left--;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc_load"},     32'(pc_load),     32'(m_load));
        chk({tag, ".pc_target"},   32'(pc_target),   32'(m_tgt));
        chk({tag, ".flush"},       32'(flush),       32'(m_left > 0));
        chk({tag, ".clr_en"},      32'(clr_en),      32'(m_clr));
        chk({tag, ".clr_mask"},    32'(clr_mask),    32'(m_cmask));
        chk({tag, ".int_save"},    32'(int_save),    32'(m_save));
        chk({tag, ".restore_en"},  32'(restore_en),  32'(m_ren));
        chk({tag, ".restore_val"}, 32'(restore_val), 32'(m_rval));
        chk({tag, ".busy"},        32'(busy),        32'(m_left > 0));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic idle_in();
        br_valid = 0; int_req = 0; rti = 0; alu_flag_en = 0;
        alu_flag_mask = '0; alu_flags = '0; br_op = BR_NONE;
    endtask

    initial begin
        vt[0] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, BR_JZ,  8'h3C, 1'b1, 1'b1, 4'b0001};
        vt[1] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, BR_JC,  8'h11, 1'b0, 1'b0, 4'b0000};
        vt[2] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, BR_JMP, 8'hF0, 1'b1, 1'b0, 4'b0000};
        vt[3] = '{4'b0000, 1'b1, 4'b0010, 4'b0010, BR_JN,  8'h22, 1'b1, 1'b1, 4'b0010};
        vt[4] = '{4'b0000, 1'b1, 4'b0000, 4'b0010, BR_JN,  8'h23, 1'b0, 1'b0, 4'b0000};
        vt[5] = '{4'b1000, 1'b0, 4'b0000, 4'b0000, BR_JV,  8'h44, 1'b1, 1'b1, 4'b1000};
        vt[6] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, BR_NONE,8'h55, 1'b0, 1'b0, 4'b0000};
        vt[7] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 3'd7,   8'h66, 1'b0, 1'b0, 4'b0000};
        vt[8] = '{4'b0100, 1'b1, 4'b0100, 4'b0000, BR_JC,  8'h77, 1'b0, 1'b0, 4'b0000};
        vt[9] = '{4'b0000, 1'b1, 4'b1111, 4'b0001, BR_JZ,  8'h88, 1'b1, 1'b1, 4'b0001};

        model_reset();
        idle_in();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;
        tick("post_reset");

        // Table vectors, each applied from IDLE
        foreach (vt[k]) begin
            idle_in();
            ccr_in = vt[k].ccr; alu_flag_en = vt[k].fen; alu_flag_mask = vt[k].fmask;
            alu_flags = vt[k].flags; br_op = vt[k].op; br_target = vt[k].tgt; br_valid = 1;
            tick("vec");
            chk($sformatf("vec%0d.pc_load", k), 32'(pc_load), 32'(vt[k].load));
            chk($sformatf("vec%0d.clr_en", k), 32'(clr_en), 32'(vt[k].clr));
            chk($sformatf("vec%0d.clr_mask", k), 32'(clr_mask), 32'(vt[k].cmask));
            if (vt[k].load) chk($sformatf("vec%0d.pc_target", k), 32'(pc_target), 32'(vt[k].tgt));
            idle_in();
            repeat (3) tick("vec_tail");
        end

        // Flush length after a taken JZ
        ccr_in = 4'b0001; br_op = BR_JZ; br_target = 8'h3C; br_valid = 1;
        tick("jz");
        idle_in();
        chk("jz.flush1", 32'(flush), 32'd1);
        tick("jz_f2");
        chk("jz.flush2", 32'(flush), 32'd1);
        chk("jz.pc_load_pulse", 32'(pc_load), 32'd0);
        tick("jz_f3");
        chk("jz.flush_drop", 32'(flush), 32'd0);
        chk("jz.busy_drop", 32'(busy), 32'd0);

        // Interrupt save then restore
        ccr_in = 4'b1010; int_req = 1;
        tick("irq");
        int_req = 0;
        chk("irq.int_save", 32'(int_save), 32'd1);
        chk("irq.busy1", 32'(busy), 32'd1);
        tick("irq_b2");
        chk("irq.busy2", 32'(busy), 32'd1);
        chk("irq.save_pulse", 32'(int_save), 32'd0);
        tick("irq_b3");
        chk("irq.busy_end", 32'(busy), 32'd0);
        ccr_in = 4'b0000; rti = 1;
        tick("rti");
        rti = 0;
        chk("rti.restore_en", 32'(restore_en), 32'd1);
        chk("rti.restore_val", 32'(restore_val), 32'hA);
        tick("rti_after");

        // Taken JV collides with int_req: branch first, save on first IDLE cycle
        ccr_in = 4'b1000; br_op = BR_JV; br_target = 8'h5A; br_valid = 1; int_req = 1;
        tick("coll");
        idle_in();
        chk("coll.pc_load", 32'(pc_load), 32'd1);
        chk("coll.no_save", 32'(int_save), 32'd0);
        tick("coll_f2");
        chk("coll.no_save2", 32'(int_save), 32'd0);
        tick("coll_idle");
        chk("coll.no_save3", 32'(int_save), 32'd0);
        ccr_in = 4'b0110;
        tick("coll_save");
        chk("coll.int_save", 32'(int_save), 32'd1);
        ccr_in = 4'b0000;
        repeat (2) tick("coll_tail");
        rti = 1;
        tick("coll_rti");
        rti = 0;
        chk("coll.restore_val", 32'(restore_val), 32'h6);

        // rti and int_req together: restore first, interrupt follows
        ccr_in = 4'b0011; rti = 1; int_req = 1;
        tick("rti_irq");
        rti = 0; int_req = 0;
        chk("rti_irq.restore_en", 32'(restore_en), 32'd1);
        chk("rti_irq.no_save", 32'(int_save), 32'd0);
        tick("rti_irq2");
        chk("rti_irq.deferred_save", 32'(int_save), 32'd1);
        repeat (3) tick("rti_irq_tail");

        // Reset in the middle of a flush
        ccr_in = 4'b0000; br_op = BR_JMP; br_target = 8'hF0; br_valid = 1;
        tick("pre_rst");
        idle_in();
        #2 rst_n = 0;
        model_reset();
        #1;
        check_all("mid_rst");
        chk("mid_rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) tick("post_mid_rst");
        chk("post_mid_rst.pc_load", 32'(pc_load), 32'd0);
        rti = 1;
        tick("rst_shadow");
        rti = 0;
        chk("rst.shadow_zero", 32'(restore_val), 32'd0);

        // Random stimulus against the model
        for (int c = 0; c < 600; c++) begin
            ccr_in        = 4'($urandom);
            alu_flag_en   = 1'($urandom);
            alu_flag_mask = 4'($urandom);
            alu_flags     = 4'($urandom);
            br_valid      = ($urandom_range(0, 1) == 1);
            br_op         = 3'($urandom);
            br_target     = 8'($urandom);
            int_req       = ($urandom_range(0, 9) == 0);
            rti           = ($urandom_range(0, 14) == 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
